// File: rtl/kypd_entry.sv
// Keypad entry: synchronizes and debounces key presses, then edits a
// 4-digit hex buffer with backspace, clear and enter actions.
module kypd_entry #(
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic [3:0]  key_code,
  input  logic        key_pressed,
  output logic        key_strobe,
  output logic [3:0]  key_last,
  output logic [15:0] digits,
  output logic [2:0]  digit_count,
  output logic        entry_valid,
  output logic [15:0] entry_value,
  output logic        overflow
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, sync2_q;
  logic [3:0]    code_q, code_d;
  logic          act_q;
  logic          strobe;
  logic          is_dig;

  logic [3:0]  last_q, last_d;
  logic [15:0] dig_q, dig_d;
  logic [2:0]  dcnt_q, dcnt_d;
  logic        ev_q, ev_d;
  logic [15:0] val_q, val_d;
  logic        ovf_q, ovf_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    strobe  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
          code_d  = key_code;
        end
      end
      PRESS_DB: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          // Accept with the code present now, not the one seen on entry.
          state_d = HELD;
          strobe  = 1'b1;
          code_d  = key_code;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
      end
      RELEASE_DB: begin
        if (sync2_q) begin
          state_d = HELD;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign is_dig = (code_q <= 4'd9);

  always_comb begin
    last_d = last_q;
    dig_d  = dig_q;
    dcnt_d = dcnt_q;
    ev_d   = 1'b0;
    val_d  = val_q;
    ovf_d  = ovf_q;
    if (act_q) begin
      last_d = code_q;
      unique case (1'b1)
        is_dig: begin
          if (dcnt_q < 3'd4) begin
            dig_d  = {dig_q[11:0], code_q};
            dcnt_d = dcnt_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        (code_q == 4'hB): begin
          if (dcnt_q != 3'd0) begin
            dig_d  = {4'h0, dig_q[15:4]};
            dcnt_d = dcnt_q - 3'd1;
          end
        end
        (code_q == 4'hC): begin
          dig_d  = '0;
          dcnt_d = '0;
          ovf_d  = 1'b0;
        end
        (code_q == 4'hE): begin
          val_d  = dig_q;
          ev_d   = 1'b1;
          dig_d  = '0;
          dcnt_d = '0;
          ovf_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      act_q   <= 1'b0;
      last_q  <= '0;
      dig_q   <= '0;
      dcnt_q  <= '0;
      ev_q    <= 1'b0;
      val_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= key_pressed;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      act_q   <= strobe;
      last_q  <= last_d;
      dig_q   <= dig_d;
      dcnt_q  <= dcnt_d;
      ev_q    <= ev_d;
      val_q   <= val_d;
      ovf_q   <= ovf_d;
    end
  end

  assign key_strobe  = strobe;
  assign key_last    = last_q;
  assign digits      = dig_q;
  assign digit_count = dcnt_q;
  assign entry_valid = ev_q;
  assign entry_value = val_q;
  assign overflow    = ovf_q;

endmodule
